// File: rtl/riscv_hazard_unit_mc_pkg.sv
// Shared encodings for the multi-cycle hazard unit: forwarding selects,
// result-source codes, memory-wait FSM states and the forwarding priority rule.
package riscv_hazard_unit_mc_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERROR
    } hazard_state_e;

    // The memory stage holds the younger result, so it beats writeback.
    function automatic logic [1:0] fwd_select(input logic hit_m, input logic hit_w);
        if (hit_m) return FWD_M;
        if (hit_w) return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/riscv_hazard_unit_mc_sat_counter.sv
// Saturating up-counter with synchronous clear; the clear beats the increment.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != '1))
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/riscv_hazard_unit_mc.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush, plus a
// memory-ready freeze with a watchdog and saturating stall/flush counters.
module riscv_hazard_unit_mc
    import riscv_hazard_unit_mc_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic [1:0]            ResultSrcE,
    input  logic                  PCSrcE,
    input  logic                  MemAccessM,
    input  logic                  MemReadyM,
    input  logic                  CountClear,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MemBusy,
    output logic                  MemError,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount
);

    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    hazard_state_e     state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_error_q, mem_error_d;
    logic              mem_stall;
    logic              lw_stall;

    assign ForwardAE = fwd_select(RegWriteM && (Rs1E != '0) && (Rs1E == RdM),
                                  RegWriteW && (Rs1E != '0) && (Rs1E == RdW));
    assign ForwardBE = fwd_select(RegWriteM && (Rs2E != '0) && (Rs2E == RdM),
                                  RegWriteW && (Rs2E != '0) && (Rs2E == RdW));

    assign lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_stall  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                mem_stall = MemAccessM && !MemReadyM;
                if (mem_stall) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            S_WAIT: begin
                mem_stall = !MemReadyM;
                if (MemReadyM)
                    state_d = S_IDLE;
                else if (wait_cnt_q == WAIT_LAST)
                    state_d = S_ERROR;
                else
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
            S_ERROR: mem_stall = 1'b1;
            default: state_d = S_IDLE;
        endcase
        mem_error_d = (state_d == S_ERROR);
    end

    // A freeze holds everything up to M, so a resolved branch in E waits for it.
    always_comb begin
        StallF = lw_stall;
        StallD = lw_stall;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = PCSrcE;
        FlushE = lw_stall || PCSrcE;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign MemBusy  = mem_stall;
    assign MemError = mem_error_q;

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallF),
        .clr   (CountClear),
        .count (StallCount)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (PCSrcE && !mem_stall),
        .clr   (CountClear),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_riscv_hazard_unit_mc.sv
// Directed bench for riscv_hazard_unit_mc (CNT_W=4, TIMEOUT=4): expectations are
// queued per cycle by the stimulus and compared by a negedge monitor.
module tb_riscv_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MemAccessM, MemReadyM, CountClear;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MemBusy, MemError;
    logic [3:0] StallCount, FlushCount;

    riscv_hazard_unit_mc #(.REG_ADDR_W(5), .CNT_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
        .MemReadyM(MemReadyM), .CountClear(CountClear),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemBusy(MemBusy), .MemError(MemError),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {SIG_FA, SIG_FB, SIG_SF, SIG_SD, SIG_SE, SIG_SM, SIG_FD, SIG_FE,
                  SIG_FW, SIG_BUSY, SIG_ERR, SIG_SCNT, SIG_FCNT} sig_e;
    typedef struct {
        int    cyc;
        string name;
        sig_e  sig;
        int    exp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks_total  = 0;
    int   checks_passed = 0;

    function automatic int actual(input sig_e s);
        case (s)
            SIG_FA:   return int'(ForwardAE);
            SIG_FB:   return int'(ForwardBE);
            SIG_SF:   return int'(StallF);
            SIG_SD:   return int'(StallD);
            SIG_SE:   return int'(StallE);
            SIG_SM:   return int'(StallM);
            SIG_FD:   return int'(FlushD);
            SIG_FE:   return int'(FlushE);
            SIG_FW:   return int'(FlushW);
            SIG_BUSY: return int'(MemBusy);
            SIG_ERR:  return int'(MemError);
            SIG_SCNT: return int'(StallCount);
            SIG_FCNT: return int'(FlushCount);
            default:  return -1;
        endcase
    endfunction

    task automatic expect_sig(input string name, input sig_e s, input int v);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.sig  = s;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic expect_ctl(input string tag, input int sf, input int se,
                              input int fd, input int fe, input int fw);
        expect_sig({tag, "_stallF"}, SIG_SF, sf);
        expect_sig({tag, "_stallD"}, SIG_SD, sf);
        expect_sig({tag, "_stallE"}, SIG_SE, se);
        expect_sig({tag, "_stallM"}, SIG_SM, se);
        expect_sig({tag, "_flushD"}, SIG_FD, fd);
        expect_sig({tag, "_flushE"}, SIG_FE, fe);
        expect_sig({tag, "_flushW"}, SIG_FW, fw);
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks_total++;
            if (mon_e.cyc != cyc)
                $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                         mon_e.name, mon_e.cyc, cyc);
            else if (actual(mon_e.sig) != mon_e.exp)
                $display("FAIL %s (cycle %0d): got %0d, expected %0d",
                         mon_e.name, cyc, actual(mon_e.sig), mon_e.exp);
            else
                checks_passed++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00; PCSrcE = 1'b0;
        MemAccessM = 1'b0; MemReadyM = 1'b0; CountClear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_idle();

        // Reset state
        next_cycle();
        expect_sig("rst_busy", SIG_BUSY, 0);
        expect_sig("rst_err", SIG_ERR, 0);
        expect_sig("rst_scnt", SIG_SCNT, 0);
        expect_sig("rst_fcnt", SIG_FCNT, 0);
        expect_ctl("rst", 0, 0, 0, 0, 0);

        // Forwarding: M priority, x0 never forwarded, W-only path
        next_cycle();
        reset = 1'b0;
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        RegWriteW = 1'b1; RdW = 5'd5; Rs2E = 5'd5;
        expect_sig("fwd_a_m", SIG_FA, 2);
        expect_sig("fwd_b_m", SIG_FB, 2);
        expect_sig("fwd_nostall", SIG_SF, 0);
        next_cycle();
        RdM = 5'd0; Rs1E = 5'd0;
        expect_sig("fwd_a_x0", SIG_FA, 0);
        expect_sig("fwd_b_w", SIG_FB, 1);
        next_cycle();
        RegWriteM = 1'b0; RdM = 5'd3; Rs1E = 5'd3; RdW = 5'd3;
        expect_sig("fwd_a_w_only", SIG_FA, 1);
        expect_sig("fwd_b_none", SIG_FB, 0);

        // Load-use stall, then RdE=0 gives none; CountClear afterwards
        next_cycle();
        set_idle();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        expect_ctl("lw", 1, 0, 0, 1, 0);
        expect_sig("lw_scnt0", SIG_SCNT, 0);
        next_cycle();
        RdE = 5'd0; Rs2D = 5'd0;
        CountClear = 1'b1;
        expect_ctl("lw_rd0", 0, 0, 0, 0, 0);
        expect_sig("lw_scnt1", SIG_SCNT, 1);

        // Three-cycle memory freeze with a held taken branch
        next_cycle();
        set_idle();
        MemAccessM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
        expect_sig("clr_scnt", SIG_SCNT, 0);
        for (int i = 0; i < 3; i++) begin
            expect_ctl("frz", 1, 1, 0, 0, 1);
            expect_sig("frz_busy", SIG_BUSY, 1);
            expect_sig("frz_fcnt", SIG_FCNT, 0);
            next_cycle();
        end
        MemReadyM = 1'b1;
        expect_ctl("rdy", 0, 0, 1, 1, 0);
        expect_sig("rdy_busy", SIG_BUSY, 0);
        expect_sig("rdy_scnt", SIG_SCNT, 3);
        next_cycle();
        set_idle();
        expect_sig("post_busy", SIG_BUSY, 0);
        expect_sig("post_scnt", SIG_SCNT, 3);
        expect_sig("post_fcnt", SIG_FCNT, 1);

        // Ready in the same cycle as the access: no stall, stays idle
        next_cycle();
        MemAccessM = 1'b1; MemReadyM = 1'b1;
        expect_sig("fast_busy", SIG_BUSY, 0);
        expect_sig("fast_stallF", SIG_SF, 0);
        next_cycle();
        set_idle();
        expect_sig("fast_idle_busy", SIG_BUSY, 0);

        // Watchdog: four frozen cycles, then sticky error
        next_cycle();
        MemAccessM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_sig("wd_busy", SIG_BUSY, 1);
            expect_sig("wd_err_low", SIG_ERR, 0);
            next_cycle();
        end
        expect_sig("wd_err_set", SIG_ERR, 1);
        expect_sig("wd_busy5", SIG_BUSY, 1);
        next_cycle();
        MemAccessM = 1'b0; MemReadyM = 1'b1; PCSrcE = 1'b1;
        expect_ctl("err_hold", 1, 1, 0, 0, 1);
        expect_sig("err_sticky", SIG_ERR, 1);
        expect_sig("err_scnt", SIG_SCNT, 8);
        expect_sig("err_fcnt", SIG_FCNT, 1);
        next_cycle();
        reset = 1'b1;
        set_idle();
        next_cycle();
        reset = 1'b0;
        expect_sig("err_rst_err", SIG_ERR, 0);
        expect_sig("err_rst_busy", SIG_BUSY, 0);
        expect_sig("err_rst_scnt", SIG_SCNT, 0);
        expect_sig("err_rst_fcnt", SIG_FCNT, 0);

        // Saturation at 15 over 21 load-use cycles, then clear-with-stall
        ResultSrcE = 2'b01; RdE = 5'd9; Rs1D = 5'd9;
        for (int i = 0; i < 21; i++) begin
            next_cycle();
            if (i == 15) expect_sig("sat_reach", SIG_SCNT, 15);
            if (i == 20) expect_sig("sat_hold", SIG_SCNT, 15);
        end
        next_cycle();
        CountClear = 1'b1;
        expect_sig("clr_stall_sf", SIG_SF, 1);
        expect_sig("clr_pre", SIG_SCNT, 15);
        next_cycle();
        set_idle();
        expect_sig("clr_wins", SIG_SCNT, 0);

        // Reset asserted during the second wait cycle
        next_cycle();
        MemAccessM = 1'b1; MemReadyM = 1'b0;
        expect_sig("mid_busy1", SIG_BUSY, 1);
        next_cycle();
        reset = 1'b1; MemAccessM = 1'b0;
        expect_sig("mid_busy2", SIG_BUSY, 1);
        next_cycle();
        reset = 1'b0;
        expect_sig("mid_rst_busy", SIG_BUSY, 0);
        expect_sig("mid_rst_sf", SIG_SF, 0);
        expect_sig("mid_rst_scnt", SIG_SCNT, 0);
        expect_sig("mid_rst_fcnt", SIG_FCNT, 0);
        expect_sig("mid_rst_err", SIG_ERR, 0);

        next_cycle();
        next_cycle();
        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            checks_total++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", mon_e.name, mon_e.cyc);
        end
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/riscv_hazard_unit_mc.md
Name: riscv_hazard_unit_mc

Overview:
- Parametrised successor to the pipeline hazard unit. Adds multi-cycle data-memory support through a ready handshake with a watchdog, a global pipeline freeze, and saturating stall/flush performance counters.
- Keeps the existing forwarding, load-use stall and branch-flush rules.
- Sits beside the datapath/controller in the riscv pipeline top and replaces the single-cycle hazard unit.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 16, width of each performance counter.
- TIMEOUT, 64, maximum consecutive not-ready memory cycles before error (>=2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- Rs1D, Rs2D  in  REG_ADDR_W  decode-stage sources
- Rs1E, Rs2E, RdE  in  REG_ADDR_W  execute-stage sources and destination
- RdM, RdW  in  REG_ADDR_W  memory and writeback destinations
- RegWriteM, RegWriteW  in  1  destination valid in M / W
- ResultSrcE  in  2  2'b01 = load in E
- PCSrcE  in  1  taken branch/jump resolved in E
- MemAccessM  in  1  load/store occupying M
- MemReadyM  in  1  memory completes this cycle
- CountClear  in  1  synchronous clear of both counters
- StallF, StallD, StallE, StallM  out  1  hold stage registers
- FlushD, FlushE, FlushW  out  1  bubble into D / E / W register
- ForwardAE, ForwardBE  out  2  00 regfile, 10 from M, 01 from W
- MemBusy  out  1  memory freeze active
- MemError  out  1  sticky watchdog error
- StallCount, FlushCount  out  CNT_W  performance counters

Behaviour:
- FSM states are IDLE, WAIT, ERROR. Reset puts the FSM in IDLE, clears wait_cnt, StallCount, FlushCount and MemError.
- Combinational outputs follow the rules below even while reset is asserted; in IDLE they follow the inputs.
- Forwarding:
  - ForwardAE = 10 if RegWriteM && Rs1E!=0 && Rs1E==RdM.
  - Otherwise ForwardAE = 01 if RegWriteW && Rs1E!=0 && Rs1E==RdW.
  - Otherwise ForwardAE = 00. M has priority over W.
  - ForwardBE is identical using Rs2E. Forwarding is unaffected by freeze.
- memStall is:
  - in IDLE: MemAccessM && !MemReadyM;
  - in WAIT: !MemReadyM;
  - in ERROR: 1.
- MemBusy = memStall.
- Freeze (memStall=1):
  - StallF = StallD = StallE = StallM = 1 and FlushW = 1.
  - FlushD = FlushE = 0.
  - Branch and load-use actions are suppressed; PCSrcE persists because E is held, and it is acted on when the freeze ends.
- No freeze:
  - lwStall = (ResultSrcE==01) && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
  - StallF = StallD = lwStall; StallE = StallM = FlushW = 0.
  - FlushD = PCSrcE; FlushE = lwStall || PCSrcE.
  - When lwStall and PCSrcE coincide, both apply: F/D are held, and D and E are both flushed.
- FSM transitions:
  - IDLE -> WAIT when MemAccessM && !MemReadyM; wait_cnt <= 1.
  - WAIT with MemReadyM=1 -> IDLE; that cycle is not frozen, and M advances on the next edge.
  - WAIT with !MemReadyM and wait_cnt == TIMEOUT-1 -> ERROR; this is the edge ending the TIMEOUT-th frozen cycle.
  - WAIT otherwise: wait_cnt increments.
  - MemAccessM && MemReadyM in IDLE gives zero stall, as for a single-cycle access.
  - ERROR is terminal until reset. MemError = 1 in ERROR and 0 elsewhere; it is registered and visible the cycle after entry.
- Counters:
  - StallCount += 1 each cycle StallF = 1, whether from freeze or lwStall.
  - FlushCount += 1 each cycle PCSrcE && !memStall.
  - Both saturate at 2^CNT_W-1.
  - Priority: reset > CountClear > increment. CountClear with an increment in the same cycle gives 0.
  - Counters keep counting in ERROR.

Decomposition:
- Shared package holds:
  - FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - RESULT_LOAD = 2'b01;
  - the FSM state enum.
- One sub-module, hazard_sat_counter (width CNT_W; inc, clr inputs), instantiated twice.
- Forwarding and stall logic stay inline.

Test Plan:
- RegWriteM=1, RdM=5, Rs1E=5, RegWriteW=1, RdW=5, Rs2E=5 -> ForwardAE=10, ForwardBE=10. With RdM=0 and Rs1E=0 -> ForwardAE=00.
- ResultSrcE=01, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=1, FlushE=1, FlushD=0. StallCount increments by 1. With RdE=0 -> no stall.
- Load in M, MemReadyM low for 3 cycles then high:
  - MemBusy=1 for exactly 3 cycles with all four stalls and FlushW=1.
  - State returns to IDLE; StallCount=3.
  - PCSrcE=1 held during the freeze gives FlushD=FlushE=1 only in the ready cycle; FlushCount=1.
- TIMEOUT=4, MemReadyM held low:
  - MemBusy=1 for 4 cycles, then MemError=1 from cycle 5 onward.
  - Stalls remain asserted even after MemReadyM=1.
  - reset -> MemError=0, counters 0.
- CNT_W=4: 20 load-use stall cycles -> StallCount=15, stays at 15. CountClear together with a stall in the same cycle -> 0 next cycle.
- Reset asserted mid-WAIT (cycle 2) -> next cycle state is IDLE. If MemAccessM=0, MemBusy=0 and the counters are 0.
